// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the pair-matching game controller.
// MG_CHECK stops elaboration with msg when a parameter combination is unsupported.
`define MG_CHECK(cond, label, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

package memory_game_pkg;

    typedef enum logic [2:0] {
        ST_FIRST,
        ST_SECOND,
        ST_EVAL,
        ST_HIDE,
        ST_DONE
    } state_t;

    localparam int unsigned MAX_SYM_W    = 16;
    localparam int unsigned MAX_LAYOUT_W = 4096;

    // Symbol of card idx; the caller narrows the result to its own SYM_W.
    function automatic logic [MAX_SYM_W-1:0] sym_of(input logic [MAX_LAYOUT_W-1:0] layout,
                                                    input int unsigned idx,
                                                    input int unsigned sym_w);
        logic [MAX_LAYOUT_W-1:0] shifted;
        shifted = layout >> (idx * sym_w);
        return shifted[MAX_SYM_W-1:0];
    endfunction

endpackage

// File: rtl/memory_game_ctrl_hide_timer.sv
// Loadable down-counter that times how long a mismatched pair stays visible.
module hide_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Pair-matching game controller: flip handshake, match evaluation,
// timed hiding of mismatched pairs, score counters and game-over flag.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned NUM_CARDS   = 16,
    parameter int unsigned SYM_W       = 3,
    parameter int unsigned HIDE_CYCLES = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned ID_W        = $clog2(NUM_CARDS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_game,
    input  logic [NUM_CARDS*SYM_W-1:0] card_sym,
    input  logic                       flip_valid,
    input  logic [ID_W-1:0]            flip_id,
    output logic                       flip_ready,
    output logic                       reject,
    output logic [NUM_CARDS-1:0]       face_up,
    output logic [NUM_CARDS-1:0]       matched,
    output logic                       match_pulse,
    output logic                       mismatch_pulse,
    output logic [SYM_W-1:0]           match_sym,
    output logic [CNT_W-1:0]           pairs_found,
    output logic [CNT_W-1:0]           attempts,
    output logic                       game_over
);

    localparam int unsigned LAYOUT_W    = NUM_CARDS * SYM_W;
    localparam int unsigned HT_W        = (HIDE_CYCLES > 0) ? $clog2(HIDE_CYCLES + 1) : 1;
    localparam int unsigned HIDE_LOAD   = (HIDE_CYCLES > 0) ? HIDE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] PAIRS_TOTAL = CNT_W'(NUM_CARDS / 2);

    `MG_CHECK((NUM_CARDS >= 2) && (NUM_CARDS % 2 == 0), g_chk_cards, "NUM_CARDS must be even and >= 2")
    `MG_CHECK(CNT_W >= $clog2(NUM_CARDS / 2 + 1), g_chk_cnt, "CNT_W too narrow for pairs_found")
    `MG_CHECK((SYM_W <= MAX_SYM_W) && (LAYOUT_W <= MAX_LAYOUT_W), g_chk_sym, "layout wider than sym_of supports")

    state_t                state, state_d;
    logic [LAYOUT_W-1:0]   layout, layout_d;
    logic [ID_W-1:0]       card1, card1_d, card2, card2_d;
    logic [NUM_CARDS-1:0]  face_up_d, matched_d;
    logic                  reject_d, match_pulse_d, mismatch_pulse_d, game_over_d;
    logic [SYM_W-1:0]      match_sym_d, sym1, sym2;
    logic [CNT_W-1:0]      pairs_d, attempts_d;
    logic                  timer_load, timer_en, timer_zero;
    logic                  in_range, legal;

    assign sym1     = SYM_W'(sym_of(MAX_LAYOUT_W'(layout), 32'(card1), SYM_W));
    assign sym2     = SYM_W'(sym_of(MAX_LAYOUT_W'(layout), 32'(card2), SYM_W));
    assign in_range = (32'(flip_id) < NUM_CARDS);
    assign legal    = in_range && !face_up[flip_id] && !matched[flip_id];

    hide_timer #(.W(HT_W)) u_hide_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (HT_W'(HIDE_LOAD)),
        .zero_c   (timer_zero)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d          = state;
        layout_d         = layout;
        card1_d          = card1;
        card2_d          = card2;
        face_up_d        = face_up;
        matched_d        = matched;
        reject_d         = 1'b0;
        match_pulse_d    = 1'b0;
        mismatch_pulse_d = 1'b0;
        match_sym_d      = match_sym;
        pairs_d          = pairs_found;
        attempts_d       = attempts;
        game_over_d      = game_over;
        timer_load       = 1'b0;
        timer_en         = 1'b0;

        if (new_game) begin
            layout_d    = card_sym;
            face_up_d   = '0;
            matched_d   = '0;
            pairs_d     = '0;
            attempts_d  = '0;
            game_over_d = 1'b0;
            state_d     = ST_FIRST;
        end else begin
            unique case (state)
                ST_FIRST, ST_SECOND: begin
                    if (flip_valid) begin
                        if (!legal) begin
                            reject_d = 1'b1;
                        end else begin
                            face_up_d[flip_id] = 1'b1;
                            if (state == ST_FIRST) begin
                                card1_d = flip_id;
                                state_d = ST_SECOND;
                            end else begin
                                card2_d = flip_id;
                                state_d = ST_EVAL;
                            end
                        end
                    end
                end
                ST_EVAL: begin
                    attempts_d = (attempts == '1) ? attempts : attempts + CNT_W'(1);
                    if (sym1 == sym2) begin
                        matched_d[card1] = 1'b1;
                        matched_d[card2] = 1'b1;
                        match_sym_d      = sym1;
                        match_pulse_d    = 1'b1;
                        pairs_d          = pairs_found + CNT_W'(1);
                        if (pairs_d == PAIRS_TOTAL) begin
                            game_over_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            state_d = ST_FIRST;
                        end
                    end else begin
                        mismatch_pulse_d = 1'b1;
                        if (HIDE_CYCLES == 0) begin
                            face_up_d[card1] = 1'b0;
                            face_up_d[card2] = 1'b0;
                            state_d          = ST_FIRST;
                        end else begin
                            timer_load = 1'b1;
                            state_d    = ST_HIDE;
                        end
                    end
                end
                ST_HIDE: begin
                    if (timer_zero) begin
                        face_up_d[card1] = 1'b0;
                        face_up_d[card2] = 1'b0;
                        state_d          = ST_FIRST;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_FIRST;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_FIRST;
            layout         <= '0;
            card1          <= '0;
            card2          <= '0;
            flip_ready     <= 1'b1;
            reject         <= 1'b0;
            face_up        <= '0;
            matched        <= '0;
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            match_sym      <= '0;
            pairs_found    <= '0;
            attempts       <= '0;
            game_over      <= 1'b0;
        end else begin
            state          <= state_d;
            layout         <= layout_d;
            card1          <= card1_d;
            card2          <= card2_d;
            flip_ready     <= (state_d == ST_FIRST) || (state_d == ST_SECOND);
            reject         <= reject_d;
            face_up        <= face_up_d;
            matched        <= matched_d;
            match_pulse    <= match_pulse_d;
            mismatch_pulse <= mismatch_pulse_d;
            match_sym      <= match_sym_d;
            pairs_found    <= pairs_d;
            attempts       <= attempts_d;
            game_over      <= game_over_d;
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Bench for memory_game_ctrl: event-scheduled game model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_memory_game_ctrl;

    localparam int N  = 8;
    localparam int SW = 2;
    localparam int H  = 3;
    localparam int CW = 8;
    localparam logic [N*SW-1:0] LAYOUT1 = 16'hE4E4;  // cards 0..7 = 0,1,2,3,0,1,2,3
    localparam logic [N*SW-1:0] LAYOUT2 = 16'h1B1B;  // cards 0..7 = 3,2,1,0,3,2,1,0

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            new_game = 1'b0;
    logic [N*SW-1:0] card_sym = '0;
    logic            flip_valid = 1'b0;
    logic [2:0]      flip_id = '0;
    logic            flip_ready, reject, match_pulse, mismatch_pulse, game_over;
    logic [N-1:0]    face_up, matched;
    logic [SW-1:0]   match_sym;
    logic [CW-1:0]   pairs_found, attempts;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model state: card contents plus scheduled evaluation/hide events
    logic [SW-1:0] m_sym [N];
    logic [N-1:0]  m_face = '0, m_matched = '0;
    logic [SW-1:0] m_msym = '0;
    bit            m_reject = 0, m_mp = 0, m_mmp = 0, m_over = 0, m_ready = 0;
    int            m_pairs = 0, m_att = 0;
    int            first_id = -1, pa = 0, pb = 0;
    int            apply_at = -1, hide_at = -1, tick = 0;

    always #5 clk = ~clk;

    memory_game_ctrl #(
        .NUM_CARDS   (N),
        .SYM_W       (SW),
        .HIDE_CYCLES (H),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_game       (new_game),
        .card_sym       (card_sym),
        .flip_valid     (flip_valid),
        .flip_id        (flip_id),
        .flip_ready     (flip_ready),
        .reject         (reject),
        .face_up        (face_up),
        .matched        (matched),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .match_sym      (match_sym),
        .pairs_found    (pairs_found),
        .attempts       (attempts),
        .game_over      (game_over)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int id;
        tick++;
        m_reject = 0;
        m_mp     = 0;
        m_mmp    = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) m_sym[i] = '0;
            m_face = '0; m_matched = '0; m_msym = '0;
            m_pairs = 0; m_att = 0; m_over = 0;
            first_id = -1; apply_at = -1; hide_at = -1;
        end else if (new_game) begin
            for (int i = 0; i < N; i++) m_sym[i] = card_sym[i*SW +: SW];
            m_face = '0; m_matched = '0;
            m_pairs = 0; m_att = 0; m_over = 0;
            first_id = -1; apply_at = -1; hide_at = -1;
        end else begin
            if (flip_valid && m_ready) begin
                id = int'(flip_id);
                if (id >= N || m_face[id] || m_matched[id]) begin
                    m_reject = 1;
                end else begin
                    m_face[id] = 1'b1;
                    if (first_id < 0) begin
                        first_id = id;
                    end else begin
                        pa = first_id; pb = id; first_id = -1;
                        apply_at = tick + 1;
                    end
                end
            end
            if (apply_at == tick) begin
                apply_at = -1;
                if (m_att < 255) m_att++;
                if (m_sym[pa] == m_sym[pb]) begin
                    m_matched[pa] = 1'b1;
                    m_matched[pb] = 1'b1;
                    m_msym = m_sym[pa];
                    m_mp = 1;
                    m_pairs++;
                    if (m_pairs == N / 2) m_over = 1;
                end else begin
                    m_mmp = 1;
                    hide_at = tick + H;
                end
            end
            if (hide_at == tick) begin
                m_face[pa] = 1'b0;
                m_face[pb] = 1'b0;
                hide_at = -1;
            end
        end
        m_ready = !m_over && apply_at < 0 && hide_at < 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("flip_ready", 32'(flip_ready), 32'(m_ready));
            chk("reject", 32'(reject), 32'(m_reject));
            chk("face_up", 32'(face_up), 32'(m_face));
            chk("matched", 32'(matched), 32'(m_matched));
            chk("match_pulse", 32'(match_pulse), 32'(m_mp));
            chk("mismatch_pulse", 32'(mismatch_pulse), 32'(m_mmp));
            chk("match_sym", 32'(match_sym), 32'(m_msym));
            chk("pairs_found", 32'(pairs_found), 32'(m_pairs));
            chk("attempts", 32'(attempts), 32'(m_att));
            chk("game_over", 32'(game_over), 32'(m_over));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic flip(input int id);
        flip_valid = 1'b1;
        flip_id    = 3'(id);
        step();
        flip_valid = 1'b0;
    endtask

    task automatic start_game(input logic [N*SW-1:0] lay);
        card_sym = lay;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_face_up", 32'(face_up), 32'h0);
        chk("rst_attempts", 32'(attempts), 32'h0);
        chk("rst_game_over", 32'(game_over), 32'h0);
        rst = 1'b0;

        // Mismatch 1/2, flips held during HIDE are ignored
        start_game(LAYOUT1);
        flip(1); flip(2); step();
        chk("s2_mismatch_pulse", 32'(mismatch_pulse), 32'h1);
        chk("s2_attempts", 32'(attempts), 32'h1);
        chk("s2_face_up", 32'(face_up), 32'h06);
        flip_valid = 1'b1; flip_id = 3'd5;
        step(); chk("s2_face_hold1", 32'(face_up), 32'h06);
        step(); chk("s2_face_hold2", 32'(face_up), 32'h06);
        chk("s2_ready_low", 32'(flip_ready), 32'h0);
        flip_valid = 1'b0;
        step(); chk("s2_face_hidden", 32'(face_up), 32'h00);
        chk("s2_ready_back", 32'(flip_ready), 32'h1);

        // Match 0/4, then illegal flips
        start_game(LAYOUT1);
        flip(0); flip(4); step();
        chk("s1_match_pulse", 32'(match_pulse), 32'h1);
        chk("s1_match_sym", 32'(match_sym), 32'h0);
        chk("s1_matched", 32'(matched), 32'h11);
        chk("s1_face_up", 32'(face_up), 32'h11);
        chk("s1_pairs", 32'(pairs_found), 32'h1);
        chk("s1_attempts", 32'(attempts), 32'h1);
        step(); chk("s1_pulse_gone", 32'(match_pulse), 32'h0);
        flip(0); chk("s3_reject_matched", 32'(reject), 32'h1);
        flip(3); chk("s3_accept3", 32'(reject), 32'h0);
        flip(3); chk("s3_reject_faceup", 32'(reject), 32'h1);
        chk("s3_face_up", 32'(face_up), 32'h19);
        flip(7); step();
        chk("s3_pairs", 32'(pairs_found), 32'h2);
        chk("s3_matched", 32'(matched), 32'h99);

        // Solve the whole board in order
        start_game(LAYOUT1);
        for (int p = 0; p < 4; p++) begin
            flip(p); flip(p + 4); step();
        end
        chk("s4_game_over", 32'(game_over), 32'h1);
        chk("s4_pairs", 32'(pairs_found), 32'h4);
        chk("s4_face_up", 32'(face_up), 32'hFF);
        chk("s4_ready", 32'(flip_ready), 32'h0);
        chk("s4_attempts", 32'(attempts), 32'h4);
        flip(0); chk("s4_ignored", 32'(reject), 32'h0);

        // new_game with a same-cycle flip in DONE
        card_sym = LAYOUT2; new_game = 1'b1; flip_valid = 1'b1; flip_id = 3'd2;
        step();
        new_game = 1'b0; flip_valid = 1'b0;
        chk("s6_face_up", 32'(face_up), 32'h0);
        chk("s6_ready", 32'(flip_ready), 32'h1);
        chk("s6_game_over", 32'(game_over), 32'h0);
        flip(0); flip(4); step();
        chk("s6_new_layout_sym", 32'(match_sym), 32'h3);
        step();

        // Reset during HIDE, then during EVAL
        flip(1); flip(2); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("s5_face_up", 32'(face_up), 32'h0);
        chk("s5_attempts", 32'(attempts), 32'h0);
        chk("s5_ready", 32'(flip_ready), 32'h1);
        flip(5); flip(6);
        rst = 1'b1; step(); rst = 1'b0;
        chk("s5_no_pulse", 32'(match_pulse), 32'h0);
        chk("s5_matched", 32'(matched), 32'h0);

        // attempts saturation
        start_game(LAYOUT1);
        for (int r = 0; r < 260; r++) begin
            flip(1); flip(2);
            repeat (4) step();
        end
        chk("sat_attempts", 32'(attempts), 32'hFF);
        chk("sat_pairs", 32'(pairs_found), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
